// File: rtl/qsfp_lane_prbs_tester.sv
// Multi-lane PRBS31 generator and self-synchronising checkers for the QSFP test path.
// One shared generator drives every lane; each lane has an independent lock FSM and error counter.
module qsfp_lane_prbs_tester #(
   parameter int unsigned LANES      = 4,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [LANES-1:0]          inject_err,
   input  logic                      clear_counters,
   output logic [LANES*DATA_W-1:0]   tx_parallel_data,
   input  logic [LANES*DATA_W-1:0]   rx_parallel_data,
   input  logic [LANES-1:0]          rx_is_lockedtodata,
   output logic [LANES-1:0]          locked,
   output logic [LANES-1:0]          lock_lost,
   output logic [LANES*CNT_W-1:0]    err_count
);

   localparam int unsigned POP_W  = $clog2(DATA_W + 1);
   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);
   localparam int unsigned SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEED   = 2'd1;
   localparam logic [1:0] ST_VERIFY = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // DATA_W serial PRBS31 steps; earliest output bit ends up in the MSB.
   function automatic logic [DATA_W-1:0] prbs_word(input logic [30:0] seed);
      logic [30:0]       s;
      logic [DATA_W-1:0] w;
      logic              b;
      s = seed;
      w = '0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         b = s[30] ^ s[27];
         s = {s[29:0], b};
         w = {w[DATA_W-2:0], b};
      end
      return w;
   endfunction

   function automatic logic [POP_W-1:0] popcount(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] t;
      logic [POP_W-1:0]  c;
      t = v;
      c = '0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         c = c + POP_W'(t[0]);
         t = t >> 1;
      end
      return c;
   endfunction

   logic [30:0]              gen_q, gen_d;
   logic [DATA_W-1:0]        gen_word;
   logic [LANES*DATA_W-1:0]  tx_q, tx_d;

   always_comb begin
      gen_word = prbs_word(gen_q);
      gen_d    = enable ? gen_word[30:0] : gen_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gen_q <= '1;
         tx_q  <= '0;
      end else begin
         gen_q <= gen_d;
         tx_q  <= tx_d;
      end
   end

   assign tx_parallel_data = tx_q;

   for (genvar n = 0; n < int'(LANES); n++) begin : g_lane
      logic [1:0]        state_q, state_d;
      logic [30:0]       chk_q, chk_d;
      logic [GOOD_W-1:0] good_q, good_d;
      logic [BAD_W-1:0]  bad_q, bad_d;
      logic              locked_q, locked_d;
      logic              lost_q, lost_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [DATA_W-1:0] rx_w, exp_w, diff_w;
      logic [POP_W-1:0]  pop;
      logic [SUM_W-1:0]  sum;
      logic              mism;

      assign tx_d[n*DATA_W +: DATA_W] = enable ? (gen_word ^ DATA_W'(inject_err[n])) : '0;

      assign rx_w   = rx_parallel_data[n*DATA_W +: DATA_W];
      assign exp_w  = prbs_word(chk_q);
      assign diff_w = rx_w ^ exp_w;
      assign mism   = |diff_w;
      assign pop    = popcount(diff_w);
      assign sum    = SUM_W'(cnt_q) + SUM_W'(pop);

      always_comb begin
         state_d  = state_q;
         chk_d    = chk_q;
         good_d   = good_q;
         bad_d    = bad_q;
         locked_d = locked_q;
         lost_d   = lost_q;
         cnt_d    = cnt_q;
         if (!enable || !rx_is_lockedtodata[n]) begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: state_d = ST_SEED;
               ST_SEED: begin
                  chk_d   = rx_w[30:0];
                  good_d  = '0;
                  state_d = ST_VERIFY;
               end
               ST_VERIFY: begin
                  chk_d = exp_w[30:0];
                  if (mism) begin
                     state_d = ST_SEED;
                  end else begin
                     good_d = good_q + GOOD_W'(1);
                     if (good_q + GOOD_W'(1) == GOOD_W'(LOCK_CNT)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        bad_d    = '0;
                     end
                  end
               end
               default: begin
                  // Prediction always advances so line errors cannot corrupt it.
                  chk_d = exp_w[30:0];
                  if (mism) begin
                     cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum);
                     bad_d = bad_q + BAD_W'(1);
                     if (bad_q + BAD_W'(1) == BAD_W'(UNLOCK_CNT)) begin
                        state_d  = ST_SEED;
                        locked_d = 1'b0;
                        lost_d   = 1'b1;
                     end
                  end else begin
                     bad_d = '0;
                  end
               end
            endcase
         end
         if (clear_counters) begin
            cnt_d  = '0;
            lost_d = 1'b0;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q  <= ST_IDLE;
            chk_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
         end else begin
            state_q  <= state_d;
            chk_q    <= chk_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
            cnt_q    <= cnt_d;
         end
      end

      assign locked[n]                    = locked_q;
      assign lock_lost[n]                 = lost_q;
      assign err_count[n*CNT_W +: CNT_W]  = cnt_q;
   end

endmodule

// File: tb/tb_qsfp_lane_prbs_tester.sv
// Directed bench for qsfp_lane_prbs_tester: a 4-lane loopback instance plus a
// 1-lane CNT_W=4 instance for counter saturation and clear priority.
module tb_qsfp_lane_prbs_tester;
   localparam int unsigned LANES = 4;
   localparam int unsigned DW    = 64;
   localparam int unsigned CW    = 32;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   enable;
   logic [LANES-1:0]       inject_err;
   logic                   clear_counters;
   logic [LANES*DW-1:0]    tx;
   logic [LANES*DW-1:0]    rx;
   logic [LANES-1:0]       cdr;
   logic [LANES-1:0]       locked;
   logic [LANES-1:0]       lock_lost;
   logic [LANES*CW-1:0]    err_count;
   logic [LANES-1:0]       force_zero;

   logic [DW-1:0]          s_tx;
   logic [0:0]             s_inj;
   logic [0:0]             s_locked;
   logic [0:0]             s_lost;
   logic [3:0]             s_cnt;

   int                     nvec = 0;
   int                     nerr = 0;
   logic [30:0]            m_state;
   logic [DW-1:0]          m_word;

   always #5 clk = ~clk;

   for (genvar n = 0; n < int'(LANES); n++) begin : g_rx
      assign rx[n*DW +: DW] = force_zero[n] ? '0 : tx[n*DW +: DW];
   end

   qsfp_lane_prbs_tester #(.LANES(4), .DATA_W(64), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_W(32)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .inject_err(inject_err),
      .clear_counters(clear_counters), .tx_parallel_data(tx), .rx_parallel_data(rx),
      .rx_is_lockedtodata(cdr), .locked(locked), .lock_lost(lock_lost), .err_count(err_count)
   );

   qsfp_lane_prbs_tester #(.LANES(1), .DATA_W(64), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .enable(enable), .inject_err(s_inj),
      .clear_counters(clear_counters), .tx_parallel_data(s_tx), .rx_parallel_data(s_tx),
      .rx_is_lockedtodata(1'b1), .locked(s_locked), .lock_lost(s_lost), .err_count(s_cnt)
   );

   // Reference PRBS31: serial steps, earliest bit shifted up to the MSB.
   function automatic logic [DW-1:0] m_prbs(input logic [30:0] seed);
      logic [30:0]   s;
      logic [DW-1:0] w;
      logic          b;
      s = seed;
      w = '0;
      for (int k = 0; k < 64; k++) begin
         b = s[30] ^ s[27];
         s = {s[29:0], b};
         w = {w[DW-2:0], b};
      end
      return w;
   endfunction

   function automatic logic [31:0] m_pop(input logic [DW-1:0] v);
      logic [DW-1:0] t;
      logic [31:0]   c;
      t = v;
      c = '0;
      for (int k = 0; k < 64; k++) begin
         c = c + 32'(t[0]);
         t = t >> 1;
      end
      return c;
   endfunction

   task automatic step();
      logic e;
      e = enable;
      @(posedge clk);
      if (e) begin
         m_word  = m_prbs(m_state);
         m_state = m_word[30:0];
      end
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] sum;
      logic [28:0] top_exp;
      reset          = 1'b1;
      enable         = 1'b0;
      inject_err     = '0;
      clear_counters = 1'b0;
      cdr            = '1;
      force_zero     = '0;
      s_inj          = '0;
      m_state        = 31'h7FFF_FFFF;
      m_word         = '0;
      sum            = '0;
      top_exp        = 29'h1;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("reset_tx", 256'(tx), 256'(0));
      chk("reset_locked", 256'(locked), 256'(0));
      chk("reset_lost", 256'(lock_lost), 256'(0));
      chk("reset_err", 256'(err_count), 256'(0));

      // First word from the all-ones seed: 28 zeros then a one.
      enable = 1'b1;
      step();
      chk("seed_top_bits", 256'(tx[63:35]), 256'(top_exp));
      chk("seed_all_lanes", 256'(tx), 256'({m_word, m_word, m_word, m_word}));

      repeat (4) step();
      chk("lock_not_early", 256'(locked), 256'(0));
      step();
      chk("lock_exact", 256'(locked), 256'(4'hF));

      repeat (1000) step();
      chk("clean_err_1000", 256'(err_count), 256'(0));
      chk("clean_locked_1000", 256'(locked), 256'(4'hF));

      inject_err = 4'b0010;
      step();
      inject_err = '0;
      chk("inject_tx", 256'(tx), 256'({m_word, m_word, m_word ^ 64'd1, m_word}));
      repeat (2) step();
      chk("inject_err_count", 256'(err_count), 256'({32'd0, 32'd0, 32'd1, 32'd0}));
      chk("inject_locked", 256'(locked), 256'(4'hF));

      // Lane 2 sees zeros for four LOCKED words: every expected one bit is an error.
      force_zero = 4'b0100;
      repeat (4) begin
         sum = sum + m_pop(m_word);
         step();
      end
      force_zero = '0;
      chk("unlock_locked", 256'(locked), 256'(4'b1011));
      chk("unlock_lost", 256'(lock_lost), 256'(4'b0100));
      chk("unlock_err", 256'(err_count), 256'({32'd0, sum, 32'd1, 32'd0}));
      repeat (5) step();
      chk("relock_lane2", 256'(locked), 256'(4'hF));

      clear_counters = 1'b1;
      step();
      clear_counters = 1'b0;
      chk("clear_err", 256'(err_count), 256'(0));
      chk("clear_lost", 256'(lock_lost), 256'(0));
      chk("clear_keeps_lock", 256'(locked), 256'(4'hF));

      cdr = 4'b0111;
      step();
      chk("cdr_drop_locked", 256'(locked), 256'(4'b0111));
      chk("cdr_drop_lost", 256'(lock_lost), 256'(0));
      cdr = 4'hF;
      repeat (5) step();
      chk("cdr_relock_early", 256'(locked), 256'(4'b0111));
      step();
      chk("cdr_relock", 256'(locked), 256'(4'hF));
      chk("cdr_lost_final", 256'(lock_lost), 256'(0));

      chk("sat_start_locked", 256'(s_locked), 256'(1));
      chk("sat_start_cnt", 256'(s_cnt), 256'(0));
      repeat (20) begin
         s_inj = 1'b1;
         step();
         s_inj = 1'b0;
         step();
      end
      chk("sat_hold_15", 256'(s_cnt), 256'(15));
      chk("sat_locked", 256'(s_locked), 256'(1));

      clear_counters = 1'b1;
      step();
      clear_counters = 1'b0;
      chk("sat_clear", 256'(s_cnt), 256'(0));
      s_inj = 1'b1;
      step();
      s_inj = 1'b0;
      step();
      chk("sat_one_error", 256'(s_cnt), 256'(1));
      s_inj = 1'b1;
      step();
      s_inj = 1'b0;
      clear_counters = 1'b1;
      step();
      clear_counters = 1'b0;
      chk("clear_beats_error", 256'(s_cnt), 256'(0));
      step();
      chk("clear_stays_zero", 256'(s_cnt), 256'(0));

      enable = 1'b0;
      step();
      chk("disable_tx", 256'(tx), 256'(0));
      chk("disable_locked", 256'(locked), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
